// File: rtl/adcsim_spi_pkg.sv
// Shared constants, FSM state encoding and frame-building helper for the
// serial-ADC emulator.
package adcsim_spi_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_LEAD_ZEROS = 4;
  localparam int unsigned ADC_SAMPLE_W   = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StShift = 2'd2
  } adc_state_e;

  // Frame as shifted out MSB first: leading zeros, then the sample.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_frame(input logic [ADC_SAMPLE_W-1:0] s);
    return {{ADC_LEAD_ZEROS{1'b0}}, s};
  endfunction

endpackage

// File: rtl/adcsim_spi_if.sv
// Sample stream handshake plus the SPI pins of the ADC emulator.
//   i_sample_valid/i_sample/o_sample_ready : producer -> FIFO handshake
//   i_csn/i_sck                            : SPI master chip select / clock
//   o_miso                                 : serial data back to the master
// master modport: producer + SPI master side; slave modport: the emulator.
interface adcsim_spi_if;
  import adcsim_spi_pkg::*;

  logic                    i_sample_valid;
  logic [ADC_SAMPLE_W-1:0] i_sample;
  logic                    o_sample_ready;
  logic                    i_csn;
  logic                    i_sck;
  logic                    o_miso;

  modport master (
    output i_sample_valid, i_sample, i_csn, i_sck,
    input  o_sample_ready, o_miso
  );

  modport slave (
    input  i_sample_valid, i_sample, i_csn, i_sck,
    output o_sample_ready, o_miso
  );

endinterface

// File: rtl/adcsim_fifo.sv
// Sample FIFO, 2**LGFIFO entries of WIDTH bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data (ignored when full)
//   pop/rdata  : read request (ignored when empty); rdata shows the head
//   empty/full : occupancy flags
//   ready      : !full, held low while reset is asserted
//   fill       : occupancy count
module adcsim_fifo #(
  parameter int unsigned LGFIFO = 2,
  parameter int unsigned WIDTH  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              empty,
  output logic              full,
  output logic              ready,
  output logic [LGFIFO:0]   fill
);

  localparam int unsigned Depth = 1 << LGFIFO;

  logic [WIDTH-1:0]  mem [Depth];
  logic [LGFIFO-1:0] wr_ptr_q, rd_ptr_q;
  logic [LGFIFO:0]   fill_q;
  logic              ready_en_q;
  logic              push_ok, pop_ok;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == (LGFIFO+1)'(Depth));
  // ready_en_q keeps ready low during reset and for the first cycle after.
  assign ready = ready_en_q & ~full;
  assign fill  = fill_q;
  assign rdata = mem[rd_ptr_q];

  // Pop never bypasses a same-cycle push into an empty FIFO.
  assign push_ok = push & ready;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/adcsim_spi.sv
// 12-bit serial ADC emulator. Samples queue in a FIFO; each SPI frame pops
// one and shifts out {4'b0, sample} MSB first, changing data after SCK rising
// edges so the master can sample on falling edges.
//   i_clk, i_areset_n : system clock, asynchronous active-low reset
//   bus (slave)       : sample handshake and SPI pins
//   o_busy            : frame in progress (state SHIFT)
//   o_frame_stb       : pulse after the 16th SCK rising edge
//   o_underrun        : pulse when a frame starts with the FIFO empty
//   o_abort           : pulse when CSn rises before 16 bits
//   o_fill            : FIFO occupancy
// NSYNC must lie in 1..3.
module adcsim_spi
  import adcsim_spi_pkg::*;
#(
  parameter int unsigned LGFIFO = 2,
  parameter int unsigned NSYNC  = 2
) (
  input  logic            i_clk,
  input  logic            i_areset_n,
  adcsim_spi_if.slave     bus,
  output logic            o_busy,
  output logic            o_frame_stb,
  output logic            o_underrun,
  output logic            o_abort,
  output logic [LGFIFO:0] o_fill
);

  localparam logic [4:0] FrameCnt = 5'(ADC_FRAME_BITS);

  // Synchronizers
  logic [NSYNC-1:0] csn_sync_q, sck_sync_q;
  logic [NSYNC:0]   csn_cat, sck_cat;
  logic             csn_prev_q, sck_prev_q;
  logic [NSYNC:0]   settle_q;
  logic             csn_s, sck_s, csn_rise, csn_fall, sck_rise, settled;

  assign csn_cat = {csn_sync_q, bus.i_csn};
  assign sck_cat = {sck_sync_q, bus.i_sck};

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      csn_sync_q <= '1;
      sck_sync_q <= '1;
      csn_prev_q <= 1'b1;
      sck_prev_q <= 1'b1;
      settle_q   <= '0;
    end else begin
      csn_sync_q <= csn_cat[NSYNC-1:0];
      sck_sync_q <= sck_cat[NSYNC-1:0];
      csn_prev_q <= csn_sync_q[NSYNC-1];
      sck_prev_q <= sck_sync_q[NSYNC-1];
      settle_q   <= {settle_q[NSYNC-1:0], 1'b1};
    end
  end

  assign csn_s    = csn_sync_q[NSYNC-1];
  assign sck_s    = sck_sync_q[NSYNC-1];
  assign csn_rise = csn_s & ~csn_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  // The synchronizers reset to 1; only trust CSn once real input has
  // propagated through, so CSn held low across reset cannot arm a frame.
  assign settled  = settle_q[NSYNC];

  // FIFO
  logic                    fifo_empty, fifo_full, fifo_ready, start;
  logic [ADC_SAMPLE_W-1:0] fifo_rdata;

  adcsim_fifo #(
    .LGFIFO (LGFIFO),
    .WIDTH  (ADC_SAMPLE_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_areset_n),
    .push  (bus.i_sample_valid),
    .wdata (bus.i_sample),
    .pop   (start),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .ready (fifo_ready),
    .fill  (o_fill)
  );

  assign bus.o_sample_ready = fifo_ready;

  // FSM
  adc_state_e state_q, state_d;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) state_q <= StIdle;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle:  if (settled && csn_s) state_d = StArmed;
      StArmed: if (csn_fall) begin
        state_d = StShift;
        start   = 1'b1;
      end
      StShift: if (csn_rise) state_d = StArmed;
      default: state_d = StIdle;
    endcase
  end

  // Datapath
  logic [ADC_FRAME_BITS-1:0] shreg_q;
  logic [ADC_SAMPLE_W-1:0]   last_q;
  logic [4:0]                cnt_q;
  logic                      frame_stb_q, underrun_q, abort_q;
  logic                      in_shift, shift_en;

  assign in_shift = (state_q == StShift);
  // CSn rising wins over a coincident SCK edge; edges past bit 16 are ignored.
  assign shift_en = in_shift & ~csn_rise & sck_rise & (cnt_q < FrameCnt);

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      shreg_q     <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      frame_stb_q <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      frame_stb_q <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= in_shift & csn_rise & (cnt_q < FrameCnt);
      if (start) begin
        cnt_q <= '0;
        if (fifo_empty) begin
          // Resend the previous sample rather than invent data.
          shreg_q    <= adc_frame(last_q);
          underrun_q <= 1'b1;
        end else begin
          shreg_q <= adc_frame(fifo_rdata);
          last_q  <= fifo_rdata;
        end
      end else if (shift_en) begin
        shreg_q     <= {shreg_q[ADC_FRAME_BITS-2:0], 1'b0};
        cnt_q       <= cnt_q + 1'b1;
        frame_stb_q <= (cnt_q == FrameCnt - 5'd1);
      end
    end
  end

  assign bus.o_miso  = in_shift & shreg_q[ADC_FRAME_BITS-1];
  assign o_busy      = in_shift;
  assign o_frame_stb = frame_stb_q;
  assign o_underrun  = underrun_q;
  assign o_abort     = abort_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_adcsim_spi.sv
// Directed bench for adcsim_spi: acts as sample producer and SPI master.
module tb_adcsim_spi;
  import adcsim_spi_pkg::*;

  localparam int unsigned LGFIFO  = 2;
  localparam int unsigned NSYNC   = 2;
  // Half SCK period in system clocks; longer than NSYNC+1 so MISO has
  // settled after each rising edge before the master samples on the fall.
  localparam int          SckHalf = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            busy, frame_stb, underrun, abort_o;
  logic [LGFIFO:0] fill;

  int n_checks = 0;
  int n_pass   = 0;
  int n_stb    = 0;
  int n_und    = 0;
  int n_abt    = 0;

  adcsim_spi_if bus ();

  adcsim_spi #(
    .LGFIFO (LGFIFO),
    .NSYNC  (NSYNC)
  ) dut (
    .i_clk       (clk),
    .i_areset_n  (rst_n),
    .bus         (bus),
    .o_busy      (busy),
    .o_frame_stb (frame_stb),
    .o_underrun  (underrun),
    .o_abort     (abort_o),
    .o_fill      (fill)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_stb) n_stb <= n_stb + 1;
    if (underrun)  n_und <= n_und + 1;
    if (abort_o)   n_abt <= n_abt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v, output logic acc);
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = v;
    acc                = bus.o_sample_ready;
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic spi_bits(input int n, output logic [15:0] d);
    d = '0;
    for (int i = 0; i < n; i++) begin
      d = {d[14:0], bus.o_miso};
      bus.i_sck = 1'b0;
      cyc(SckHalf);
      bus.i_sck = 1'b1;
      cyc(SckHalf);
    end
  endtask

  task automatic csn_high();
    bus.i_csn = 1'b1;
    cyc(6);
  endtask

  task automatic spi_frame(output logic [15:0] d);
    bus.i_csn = 1'b0;
    cyc(4);
    spi_bits(16, d);
    csn_high();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        acc;
    int          s0, u0, a0;
    logic [11:0] vals [5];
    vals[0] = 12'h111; vals[1] = 12'h222; vals[2] = 12'h333;
    vals[3] = 12'h444; vals[4] = 12'h555;

    bus.i_sample_valid = 1'b0;
    bus.i_sample       = '0;
    bus.i_csn          = 1'b1;
    bus.i_sck          = 1'b1;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check("rst_fill",  32'(fill), 32'd0);
    check("rst_ready", 32'(bus.o_sample_ready), 32'd0);
    check("rst_miso",  32'(bus.o_miso), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_stb",   32'({frame_stb, underrun, abort_o}), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(6);
    check("ready_after_rst", 32'(bus.o_sample_ready), 32'd1);

    // Single frame
    push(12'hA5C, acc);
    check("push_a5c_fill", 32'(fill), 32'd1);
    s0 = n_stb;
    bus.i_csn = 1'b0;
    cyc(4);
    check("busy_in_frame", 32'(busy), 32'd1);
    spi_bits(16, d);
    check("miso_after_16", 32'(bus.o_miso), 32'd0);
    csn_high();
    check("frame_a5c",     32'(d), 32'h0A5C);
    check("stb_once",      32'(n_stb - s0), 32'd1);
    check("fill_after_a5c", 32'(fill), 32'd0);
    check("busy_after",    32'(busy), 32'd0);

    // FIFO full
    for (int i = 0; i < 5; i++) begin
      push(vals[i], acc);
      check($sformatf("accept_%0d", i), 32'(acc), (i < 4) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(fill), 32'd4);
    s0 = n_stb;
    for (int i = 0; i < 4; i++) begin
      spi_frame(d);
      check($sformatf("order_%0d", i), 32'(d), 32'(adc_frame(vals[i])));
    end
    check("stb_four", 32'(n_stb - s0), 32'd4);
    check("fill_drained", 32'(fill), 32'd0);

    // Underrun resends last sample
    push(12'h123, acc);
    spi_frame(d);
    check("frame_123", 32'(d), 32'h0123);
    u0 = n_und;
    spi_frame(d);
    check("underrun_pulse", 32'(n_und - u0), 32'd1);
    check("underrun_resend", 32'(d), 32'h0123);

    // Abort discards the popped sample
    push(12'hBEE, acc);
    push(12'h0C3, acc);
    a0 = n_abt;
    bus.i_csn = 1'b0;
    cyc(4);
    spi_bits(10, d);
    csn_high();
    check("abort_bits",  32'(d), 32'h002F);
    check("abort_pulse", 32'(n_abt - a0), 32'd1);
    spi_frame(d);
    check("after_abort", 32'(d), 32'h00C3);

    // Reset mid-frame with CSn held low
    push(12'h7E1, acc);
    a0 = n_abt;
    s0 = n_stb;
    bus.i_csn = 1'b0;
    cyc(4);
    spi_bits(5, d);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(bus.o_miso), 32'd0);
    check("midrst_fill", 32'(fill), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    spi_bits(4, d);
    check("no_frame_busy", 32'(busy), 32'd0);
    check("no_frame_miso", 32'(bus.o_miso), 32'd0);
    check("no_abort_rst",  32'(n_abt - a0), 32'd0);
    check("no_stb_rst",    32'(n_stb - s0), 32'd0);
    push(12'h3C4, acc);
    csn_high();
    spi_frame(d);
    check("frame_3c4", 32'(d), 32'h03C4);

    // Push on the frame-start cycle with the FIFO empty
    u0 = n_und;
    bus.i_csn = 1'b0;
    cyc(2);
    push(12'h6B2, acc);
    cyc(1);
    spi_bits(16, d);
    csn_high();
    check("same_cyc_underrun", 32'(n_und - u0), 32'd1);
    check("same_cyc_resend",   32'(d), 32'h03C4);
    check("same_cyc_fill",     32'(fill), 32'd1);
    spi_frame(d);
    check("same_cyc_next", 32'(d), 32'h06B2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adcsim_spi.md
ADCSIM_SPI -- requirements
Module: adcsim_spi

Interface
REQ-001 SHALL have parameter LGFIFO, default 2; log2 of the sample FIFO depth (4 entries).
REQ-002 SHALL have parameter NSYNC, default 2; synchronizer stages on i_csn and i_sck, legal range 1..3.
REQ-003 SHALL have port i_clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_areset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_sample_valid  input  1  a producer offers a sample.
REQ-006 SHALL have port i_sample  input  12  the offered sample, unsigned.
REQ-007 SHALL have port o_sample_ready  output  1  the FIFO accepts; push occurs when valid and ready are both high.
REQ-008 SHALL have port i_csn  input  1  SPI chip select from the ADC master, active-low.
REQ-009 SHALL have port i_sck  input  1  SPI clock from the master; idles high.
REQ-010 SHALL have port o_miso  output  1  serial data to the master.
REQ-011 SHALL have port o_busy  output  1  a frame is in progress.
REQ-012 SHALL have port o_frame_stb  output  1  one-cycle pulse when a complete 16-bit frame has been sent.
REQ-013 SHALL have port o_underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.
REQ-014 SHALL have port o_abort  output  1  one-cycle pulse when CSn rises before 16 bits have been sent.
REQ-015 SHALL have port o_fill  output  LGFIFO+1  the FIFO occupancy.

Function
REQ-016 The block SHALL emulate a 12-bit serial ADC: frame = 4 zero bits, then sample[11:0] MSB first, 16 bits total.
REQ-017 i_csn and i_sck SHALL each pass through NSYNC flip-flops; edges SHALL be detected on the synchronized values.
REQ-018 States: IDLE, ARMED, SHIFT. IDLE->ARMED on synchronized CSn high; ARMED->SHIFT on CSn falling edge; SHIFT->ARMED on CSn rising edge.
REQ-019 On entering SHIFT, one FIFO entry SHALL be popped into a 16-bit shift register as {4'b0, sample}, and o_miso SHALL present bit 15 no later than NSYNC+1 cycles after the i_csn fall.
REQ-020 In SHIFT, each synchronized SCK rising edge SHALL shift the register left; o_miso SHALL update on the next cycle; a 5-bit counter SHALL count rising edges 0..16.
REQ-021 Data SHALL change only after SCK rising edges, so it is stable at each falling edge, where the master samples.
REQ-022 After 16 rising edges, o_miso SHALL be held at 0, o_frame_stb SHALL pulse once, and further SCK edges SHALL be ignored until CSn rises.
REQ-023 If CSn rises with counter < 16, o_abort SHALL pulse; the popped sample SHALL be discarded, not re-queued.
REQ-024 If the FIFO is empty at frame start, o_underrun SHALL pulse, and the frame SHALL resend the last popped sample (0 if none since reset).
REQ-025 Push and pop in the same cycle SHALL both take effect; with the FIFO empty, pop SHALL NOT bypass the push, so underrun is reported.
REQ-026 o_sample_ready SHALL equal !full; no push SHALL occur when full, even with a simultaneous pop.
REQ-027 o_busy SHALL be high exactly while the state is SHIFT; o_miso SHALL be 0 outside SHIFT.
REQ-028 A CSn pulse shorter than one sample at the synchronizer output SHALL produce no frame.

Reset
REQ-029 Assertion of i_areset_n low SHALL asynchronously force: state IDLE, FIFO empty (o_fill=0), o_sample_ready=0 while reset is asserted, o_miso=0, all strobes 0, last sample 0, synchronizers to 1.
REQ-030 After release, a frame SHALL start only after CSn has been observed high (IDLE->ARMED); CSn held low through reset SHALL produce no frame.
REQ-031 Reset asserted during SHIFT SHALL abandon the frame without pulsing o_abort.

Structure
REQ-032 The shared package SHALL hold ADC_FRAME_BITS=16, ADC_LEAD_ZEROS=4, ADC_SAMPLE_W=12, and the state encoding.
REQ-033 The FIFO SHALL be a sub-module adcsim_fifo (parameter LGFIFO, width 12, async active-low reset, fill output).

Verification
REQ-034 Push 12'hA5C, then drive master frame (CKPCK=2) -> 16 bits sampled at falling edges = 16'h0A5C; o_frame_stb pulses once; o_fill goes 1->0.
REQ-035 Push 5 samples with LGFIFO=2 -> 4 accepted; o_sample_ready=0 at the 5th; o_fill=4; frames return those 4 in order.
REQ-036 Frame with the FIFO empty after 12'h123 was sent -> o_underrun pulses; master receives 16'h0123 again.
REQ-037 CSn raised after 10 SCK falling edges -> o_abort pulses; the next frame carries the next queued sample.
REQ-038 Assert reset mid-frame with CSn held low, then release -> o_miso=0, o_busy=0, no frame until CSn goes high then low.
REQ-039 Push on the same cycle as frame start with the FIFO empty -> o_underrun pulses; o_fill=1 afterward; the next frame sends the pushed value.
